// File: rtl/cam_sched_pkg.sv
// Shared types and defaults for the CAM request scheduler.
// Op codes and FSM states are used by the scheduler and its bench.
package cam_sched_pkg;

  localparam int DEF_ENTRIES = 16;
  localparam int DEF_WIDTH   = 8;
  localparam int AW          = 4;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_WRITE  = 2'd1,
    OP_INSERT = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT,
    ALLOC,
    RESP
  } state_e;

endpackage

// File: rtl/cam_rr_arb.sv
// Two-requester round-robin arbiter; the pointer remembers the last grant.
// The pointer resets to 1 so requester 0 wins the first tie.
module cam_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_last <= 1'b1;
    else if (i_take && |o_grant) r_last <= o_grant[1];
  end

endmodule

// File: rtl/cam_sched.sv
// Serialises SEARCH/WRITE/INSERT requests from two requesters onto one CAM,
// tracking entry occupancy and allocating the lowest free entry on INSERT.
module cam_sched
  import cam_sched_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0][AW-1:0]    req_addr,
  input  logic [1:0][WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_found,
  output logic [AW-1:0]         rsp_addr,
  output logic                  rsp_full,
  output logic                  rsp_err,
  output logic                  cam_we,
  output logic                  cam_search,
  output logic [AW-1:0]         cam_addr,
  output logic [WIDTH-1:0]      cam_data,
  input  logic                  cam_found,
  input  logic [AW-1:0]         cam_match_addr
);

  state_e             r_state, w_next;
  op_e                r_op, w_req_op;
  logic [AW-1:0]      r_addr;
  logic [WIDTH-1:0]   r_data;
  logic               r_id;
  logic [ENTRIES-1:0] r_occ;

  logic [1:0]         w_arb_req, w_grant;
  logic               w_take, w_sel;
  logic               w_found, w_free_any;
  logic [AW-1:0]      w_free_idx;

  logic               w_we_d, w_search_d;
  logic [AW-1:0]      w_caddr_d;
  logic [WIDTH-1:0]   w_cdata_d;
  logic               w_res_load, w_res_found, w_res_full, w_res_err;
  logic [AW-1:0]      w_res_addr;
  logic               r_res_found, r_res_full, r_res_err;
  logic [AW-1:0]      r_res_addr;

  logic               r_cam_we, r_cam_search;
  logic [AW-1:0]      r_cam_addr;
  logic [WIDTH-1:0]   r_cam_data;
  logic               r_rsp_valid, r_rsp_id, r_rsp_found, r_rsp_full, r_rsp_err;
  logic [AW-1:0]      r_rsp_addr;

  assign w_arb_req = (r_state == IDLE) ? req_valid : 2'b00;

  cam_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_arb_req),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  assign req_ready = rst ? 2'b00 : w_grant;
  assign w_take    = |w_grant;
  assign w_sel     = w_grant[1];
  assign w_req_op  = op_e'(req_op[w_sel]);

  // A stale CAM hit on an unoccupied entry is not a match.
  assign w_found    = cam_found & r_occ[cam_match_addr];
  assign w_free_any = ~&r_occ;

  always_comb begin
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_occ[i]) w_free_idx = AW'(i);
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    w_we_d      = 1'b0;
    w_search_d  = 1'b0;
    w_caddr_d   = '0;
    w_cdata_d   = '0;
    w_res_load  = 1'b0;
    w_res_found = 1'b0;
    w_res_full  = 1'b0;
    w_res_err   = 1'b0;
    w_res_addr  = '0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_next = EXEC;
          case (w_req_op)
            OP_SEARCH, OP_INSERT: begin
              w_search_d = 1'b1;
              w_cdata_d  = req_data[w_sel];
            end
            OP_WRITE: begin
              w_we_d    = 1'b1;
              w_caddr_d = req_addr[w_sel];
              w_cdata_d = req_data[w_sel];
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        if (r_op == OP_SEARCH || r_op == OP_INSERT) begin
          w_next = WAIT;
        end else begin
          w_next     = RESP;
          w_res_load = 1'b1;
          w_res_err  = (r_op == OP_RSVD);
          w_res_addr = (r_op == OP_WRITE) ? r_addr : '0;
        end
      end
      WAIT: begin
        w_res_load = 1'b1;
        if (w_found) begin
          w_next      = RESP;
          w_res_found = 1'b1;
          w_res_addr  = cam_match_addr;
        end else if (r_op == OP_INSERT && w_free_any) begin
          w_next     = ALLOC;
          w_res_addr = w_free_idx;
          w_we_d     = 1'b1;
          w_caddr_d  = w_free_idx;
          w_cdata_d  = r_data;
        end else begin
          w_next     = RESP;
          w_res_full = (r_op == OP_INSERT);
        end
      end
      ALLOC:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_SEARCH;
      r_addr      <= '0;
      r_data      <= '0;
      r_id        <= 1'b0;
      r_res_found <= 1'b0;
      r_res_full  <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_op   <= w_req_op;
        r_addr <= req_addr[w_sel];
        r_data <= req_data[w_sel];
        r_id   <= w_sel;
      end
      if (w_res_load) begin
        r_res_found <= w_res_found;
        r_res_full  <= w_res_full;
        r_res_err   <= w_res_err;
        r_res_addr  <= w_res_addr;
      end
    end
  end

  // NOTE: the occupancy bitmap must be reset; the CAM contents themselves are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_occ <= '0;
    else if (w_we_d) r_occ[w_caddr_d] <= 1'b1;
  end

  // Strobes launch with the state they belong to; the response lags RESP by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cam_we     <= 1'b0;
      r_cam_search <= 1'b0;
      r_cam_addr   <= '0;
      r_cam_data   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_found  <= 1'b0;
      r_rsp_full   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_addr   <= '0;
    end else begin
      r_cam_we     <= w_we_d;
      r_cam_search <= w_search_d;
      r_cam_addr   <= w_caddr_d;
      r_cam_data   <= w_cdata_d;
      r_rsp_valid  <= (r_state == RESP);
      r_rsp_id     <= (r_state == RESP) & r_id;
      r_rsp_found  <= (r_state == RESP) & r_res_found;
      r_rsp_full   <= (r_state == RESP) & r_res_full;
      r_rsp_err    <= (r_state == RESP) & r_res_err;
      r_rsp_addr   <= (r_state == RESP) ? r_res_addr : '0;
    end
  end

  assign cam_we     = r_cam_we;
  assign cam_search = r_cam_search;
  assign cam_addr   = r_cam_addr;
  assign cam_data   = r_cam_data;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_found  = r_rsp_found;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_full   = r_rsp_full;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_cam_sched.sv
// Self-checking bench for cam_sched: behavioural CAM, directed table,
// multi-cycle corner sequences and randomised ops against a reference model.
module tb_cam_sched;
  import cam_sched_pkg::*;

  localparam int ENTRIES = 16;
  localparam int WIDTH   = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][1:0]       req_op = '0;
  logic [1:0][3:0]       req_addr = '0;
  logic [1:0][WIDTH-1:0] req_data = '0;
  logic                  rsp_valid, rsp_id, rsp_found, rsp_full, rsp_err;
  logic [3:0]            rsp_addr;
  logic                  cam_we, cam_search;
  logic [3:0]            cam_addr;
  logic [WIDTH-1:0]      cam_data;
  logic                  cam_found = 1'b0;
  logic [3:0]            cam_match_addr = '0;

  always #5 clk = ~clk;

  cam_sched #(.ENTRIES(ENTRIES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_found(rsp_found),
    .rsp_addr(rsp_addr), .rsp_full(rsp_full), .rsp_err(rsp_err),
    .cam_we(cam_we), .cam_search(cam_search), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_found(cam_found), .cam_match_addr(cam_match_addr)
  );

  // Behavioural CAM: storage survives scheduler reset, hit is registered.
  logic [WIDTH-1:0] cam_mem [ENTRIES] = '{default: '0};
  logic             cam_wr  [ENTRIES] = '{default: 1'b0};

  always @(posedge clk) begin
    if (cam_we) begin
      cam_mem[cam_addr] <= cam_data;
      cam_wr[cam_addr]  <= 1'b1;
    end
    cam_found      <= 1'b0;
    cam_match_addr <= '0;
    if (cam_search) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (cam_wr[i] && cam_mem[i] == cam_data) begin
          cam_found      <= 1'b1;
          cam_match_addr <= 4'(i);
        end
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", 32'(cam_we & cam_search), 0);
      if (!rsp_valid)
        check("rsp_idle_zero", 32'({rsp_id, rsp_found, rsp_addr, rsp_full, rsp_err}), 0);
    end
  end

  typedef struct {
    int id, op, addr, key;
    int found, raddr, full, err, lat, n_we, we_addr, n_srch;
  } vec_t;

  // Reference model: occupancy and CAM contents as the rules describe them.
  logic [WIDTH-1:0] m_key [ENTRIES];
  bit               m_wr  [ENTRIES];
  bit               m_occ [ENTRIES];
  int               m_last = 1;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_occ[i] = 1'b0;
    m_last = 1;
  endtask

  task automatic model_op(inout vec_t v);
    int hit = -1, free = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (hit < 0 && m_wr[i] && m_key[i] == WIDTH'(v.key)) hit = i;
    for (int i = 0; i < ENTRIES; i++)
      if (free < 0 && !m_occ[i]) free = i;
    v.found = 0; v.raddr = 0; v.full = 0; v.err = 0;
    v.n_we = 0; v.we_addr = 0; v.n_srch = 0;
    case (v.op)
      0: begin
        v.lat = 3; v.n_srch = 1;
        if (hit >= 0 && m_occ[hit]) begin v.found = 1; v.raddr = hit; end
      end
      1: begin
        v.lat = 2; v.n_we = 1; v.we_addr = v.addr; v.raddr = v.addr;
        m_occ[v.addr] = 1'b1; m_wr[v.addr] = 1'b1; m_key[v.addr] = WIDTH'(v.key);
      end
      2: begin
        v.n_srch = 1;
        if (hit >= 0 && m_occ[hit]) begin
          v.lat = 3; v.found = 1; v.raddr = hit;
        end else if (free >= 0) begin
          v.lat = 4; v.n_we = 1; v.we_addr = free; v.raddr = free;
          m_occ[free] = 1'b1; m_wr[free] = 1'b1; m_key[free] = WIDTH'(v.key);
        end else begin
          v.lat = 3; v.full = 1;
        end
      end
      default: begin v.lat = 2; v.err = 1; end
    endcase
  endtask

  task automatic accept(input int id, input int op, input int addr, input int key, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_op[id]    = 2'(op);
    req_addr[id]  = 4'(addr);
    req_data[id]  = WIDTH'(key);
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (req_ready[id]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 0, 1);
      req_valid[id] = 1'b0;
      return;
    end
    check("ready_onehot", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    m_last = id;
  endtask

  task automatic do_req(input vec_t v);
    bit ok;
    int lat = -1, nwe = 0, nsr = 0, weaddr = -1;
    accept(v.id, v.op, v.addr, v.key, ok);
    if (!ok) return;
    for (int n = 1; n <= 10; n++) begin
      if (cam_we) begin nwe++; weaddr = cam_addr; end
      if (cam_search) begin nsr++; check("search_key", 32'(cam_data), 32'(v.key & 8'hFF)); end
      @(posedge clk);
      #1;
      if (rsp_valid) begin lat = n; break; end
    end
    if (lat < 0) begin check("rsp_timeout", 0, 1); return; end
    check("latency",   lat, v.lat);
    check("rsp_id",    32'(rsp_id), v.id);
    check("rsp_found", 32'(rsp_found), v.found);
    check("rsp_addr",  32'(rsp_addr), v.raddr);
    check("rsp_full",  32'(rsp_full), v.full);
    check("rsp_err",   32'(rsp_err), v.err);
    check("n_cam_we",  nwe, v.n_we);
    check("n_search",  nsr, v.n_srch);
    if (v.n_we > 0) check("we_addr", weaddr, v.we_addr);
    @(posedge clk);
    #1;
    check("rsp_pulse", 32'(rsp_valid), 0);
  endtask

  function automatic vec_t mk(int id, int op, int addr, int key, int found, int raddr,
                              int full, int err, int lat, int n_we, int we_addr, int n_srch);
    vec_t v;
    v.id = id; v.op = op; v.addr = addr; v.key = key; v.found = found; v.raddr = raddr;
    v.full = full; v.err = err; v.lat = lat; v.n_we = n_we; v.we_addr = we_addr; v.n_srch = n_srch;
    return v;
  endfunction

  // Hand-written expectations: model is updated alongside but not consulted.
  task automatic run_fixed(input vec_t v);
    vec_t m = v;
    model_op(m);
    do_req(v);
  endtask

  task automatic hold_reset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    bit   ok, seen;
    int   grants[$], ids[$];
    int   exp_g;

    for (int i = 0; i < ENTRIES; i++) begin m_wr[i] = 1'b0; m_key[i] = '0; end
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_found, rsp_addr, rsp_full,
                               rsp_err, cam_we, cam_search, cam_addr, cam_data}), 0);
    rst = 1'b0;

    //        id op addr key   fnd raddr full err lat nwe weaddr nsrch
    vecs[0] = mk(0, 2, 0, 'h55, 0, 0, 0, 0, 4, 1, 0, 1);
    vecs[1] = mk(0, 2, 0, 'h55, 1, 0, 0, 0, 3, 0, 0, 1);
    vecs[2] = mk(1, 0, 0, 'hFF, 0, 0, 0, 0, 3, 0, 0, 1);
    vecs[3] = mk(1, 3, 7, 'h12, 0, 0, 0, 1, 2, 0, 0, 0);
    vecs[4] = mk(0, 1, 5, 'h77, 0, 5, 0, 0, 2, 1, 5, 0);
    vecs[5] = mk(1, 0, 0, 'h77, 1, 5, 0, 0, 3, 0, 0, 1);
    vecs[6] = mk(1, 2, 0, 'h66, 0, 1, 0, 0, 4, 1, 1, 1);
    vecs[7] = mk(0, 0, 0, 'h66, 1, 1, 0, 0, 3, 0, 0, 1);
    for (int i = 0; i < 8; i++) run_fixed(vecs[i]);

    // Reset while a SEARCH sits in WAIT: the response must be dropped.
    accept(0, 0, 0, 'h55, ok);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rsp", 32'({rsp_valid, cam_we, cam_search}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_rst", 32'(seen), 0);
    @(negedge clk);
    req_valid = 2'b11;
    req_op    = '0;
    #1;
    check("fresh_arb", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    run_fixed(mk(0, 0, 0, 'h55, 0, 0, 0, 0, 3, 0, 0, 1));

    // Fill every entry, then overflow, overwrite and look up.
    for (int i = 0; i < ENTRIES; i++)
      run_fixed(mk(i % 2, 2, 0, 'hA0 + i, 0, i, 0, 0, 4, 1, i, 1));
    run_fixed(mk(0, 2, 0, 'h99, 0, 0, 1, 0, 3, 0, 0, 1));
    run_fixed(mk(0, 1, 3, 'h99, 0, 3, 0, 0, 2, 1, 3, 0));
    run_fixed(mk(1, 0, 0, 'h99, 1, 3, 0, 0, 3, 0, 0, 1));

    // Both requesters valid continuously: grants must alternate.
    exp_g = 1 - m_last;
    @(negedge clk);
    req_valid   = 2'b11;
    req_op      = '0;
    req_data[0] = 8'h55;
    req_data[1] = 8'h55;
    for (int c = 0; c < 80 && ids.size() < 4; c++) begin
      #1;
      if (|req_ready) grants.push_back(int'(req_ready[1]));
      if (rsp_valid) ids.push_back(int'(rsp_id));
      @(negedge clk);
    end
    req_valid = 2'b00;
    if (ids.size() < 4 || grants.size() < 4) begin
      check("rr_timeout", 0, 1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check("rr_grant", grants[i], (exp_g + i) % 2);
        check("rr_rsp_id", ids[i], grants[i]);
      end
      m_last = grants[grants.size() - 1];
    end
    repeat (10) @(negedge clk);

    // Randomised traffic from a small key set so hits, stale hits and overwrites occur.
    hold_reset(2);
    for (int n = 0; n < 60; n++) begin
      int kid = $urandom_range(0, 5);
      v.id   = $urandom_range(0, 1);
      v.op   = $urandom_range(0, 3);
      v.addr = $urandom_range(0, 15);
      v.key  = (kid < 4) ? ('h10 + kid) : ('hA0 + kid - 4);
      model_op(v);
      do_req(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
